// File: rtl/cpu6502_bus_seq.sv
// cpu6502_bus_seq: phi generator, CPU reset sequencer and memory bus
// sequencer for a netlist-level 6502 core. Each phi2 bus cycle becomes one
// req/ack transaction. phi2 is stretched high until the memory responds.
//
// Memory handshake:
//   The bus fields (mem_addr, mem_we, mem_wdata) are latched one clk before
//   mem_req rises. They stay stable for as long as mem_req=1. mem_req is held
//   until a clk edge samples mem_ack=1, and it drops on the following clk.
//   mem_rdata is taken in the same clk as mem_ack. mem_ack may already be
//   high in the clk where mem_req first reads 1. An ack that arrives while
//   no request is outstanding is ignored.
module cpu6502_bus_seq #(
    parameter int HALF_CLKS   = 16,
    parameter int SETTLE_CLKS = 8,
    parameter int RESET_PHI   = 8
) (
    input  logic        clk,
    input  logic        res,
    output logic        phi,
    output logic        cpu_res,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_dbo,
    input  logic        cpu_sync,
    output logic [7:0]  cpu_dbi,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        op_fetch,
    output logic [31:0] phi_count
);

    // Phase counter: in PH1 it counts phi-low clks. While phi is high it
    // counts phi-high clks since the rise and saturates at HALF_CLKS-1, so a
    // long stretch cannot wrap it.
    localparam int CW = $clog2(HALF_CLKS) + 1;
    localparam logic [CW-1:0] HALF_LAST   = CW'(HALF_CLKS - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CLKS - 1);

    // Counts phi falls while the core is still held in reset.
    localparam int RW = $clog2(RESET_PHI) + 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_PHI - 1);

    typedef enum logic [1:0] {
        PH1        = 2'd0,
        PH2_SETTLE = 2'd1,
        PH2_WAIT   = 2'd2,
        PH2_HOLD   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic          phi_q, phi_d;
    logic          cpu_res_q, cpu_res_d;
    logic [7:0]    dbi_q, dbi_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          op_fetch_q, op_fetch_d;
    logic [31:0]   phi_count_q, phi_count_d;

    // Next-state logic for the phase sequencer, the bus transaction and the reset release.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rst_cnt_d   = rst_cnt_q;
        phi_d       = phi_q;
        cpu_res_d   = cpu_res_q;
        dbi_d       = dbi_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_fetch_d  = 1'b0;
        phi_count_d = phi_count_q;

        // While phi is high the counter tracks phi-high time, saturating.
        if (state_q != PH1 && cnt_q != HALF_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            PH1: begin
                if (cnt_q == HALF_LAST) begin
                    phi_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = PH2_SETTLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PH2_SETTLE: begin
                // The core's outputs have settled, so capture the bus cycle.
                if (cnt_q == SETTLE_LAST) begin
                    addr_d     = cpu_ab;
                    we_d       = ~cpu_rw;
                    wdata_d    = cpu_dbo;
                    op_fetch_d = cpu_sync;
                    state_d    = PH2_WAIT;
                end
            end
            PH2_WAIT: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        dbi_d = mem_rdata;
                    end
                    state_d = PH2_HOLD;
                end
            end
            PH2_HOLD: begin
                // End phi2 once it has been high for a full half period.
                if (cnt_q == HALF_LAST) begin
                    phi_d       = 1'b0;
                    cnt_d       = '0;
                    phi_count_d = phi_count_q + 32'd1;
                    state_d     = PH1;
                    if (!cpu_res_q) begin
                        if (rst_cnt_q == RST_LAST) begin
                            cpu_res_d = 1'b1;
                        end else begin
                            rst_cnt_d = rst_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = PH1;
            end
        endcase
    end

    // State and output registers. A reset abandons any outstanding transaction.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= PH1;
            cnt_q       <= '0;
            rst_cnt_q   <= '0;
            phi_q       <= 1'b0;
            cpu_res_q   <= 1'b0;
            dbi_q       <= 8'h00;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            op_fetch_q  <= 1'b0;
            phi_count_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            phi_q       <= phi_d;
            cpu_res_q   <= cpu_res_d;
            dbi_q       <= dbi_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            op_fetch_q  <= op_fetch_d;
            phi_count_q <= phi_count_d;
        end
    end

    assign phi       = phi_q;
    assign cpu_res   = cpu_res_q;
    assign cpu_dbi   = dbi_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign op_fetch  = op_fetch_q;
    assign phi_count = phi_count_q;

endmodule

// File: tb/tb_cpu6502_bus_seq.sv
// Testbench for cpu6502_bus_seq. Each phi cycle is measured by its phi-low
// length, phi-high length, the latched bus fields, op_fetch, cpu_dbi,
// phi_count and cpu_res. The expected values come from the bus-cycle timing
// rules: phi high time is the larger of HALF and settle + 1 + ack delay + 2.
module tb_cpu6502_bus_seq;

    localparam int HALF   = 16;
    localparam int SETTLE = 8;
    localparam int RPHI   = 8;
    localparam int LIMIT  = 200;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        phi;
    logic        cpu_res;
    logic [15:0] cpu_ab = 16'h0000;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_dbo = 8'h00;
    logic        cpu_sync = 1'b0;
    logic [7:0]  cpu_dbi;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        op_fetch;
    logic [31:0] phi_count;

    // Clock
    always #5 clk = ~clk;

    cpu6502_bus_seq #(
        .HALF_CLKS  (HALF),
        .SETTLE_CLKS(SETTLE),
        .RESET_PHI  (RPHI)
    ) dut (
        .clk      (clk),
        .res      (res),
        .phi      (phi),
        .cpu_res  (cpu_res),
        .cpu_ab   (cpu_ab),
        .cpu_rw   (cpu_rw),
        .cpu_dbo  (cpu_dbo),
        .cpu_sync (cpu_sync),
        .cpu_dbi  (cpu_dbi),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .op_fetch (op_fetch),
        .phi_count(phi_count)
    );

    // Scoreboard state
    int          n_vec = 0;
    int          n_bad = 0;
    logic [24:0] exp_q[$];          // {we, addr, wdata} per bus cycle
    logic [7:0]  exp_dbi = 8'h00;
    int          exp_falls = 0;
    logic [31:0] exp_pc = 32'd0;

    typedef struct {
        logic [15:0] ab;
        logic        rw;
        logic [7:0]  dbo;
        logic        sync;
        int          d;
        logic [7:0]  rdata;
        int          exp_hi;
        logic        exp_op;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_dbi   = 8'h00;
        exp_falls = 0;
        exp_pc    = 32'd0;
        exp_q.delete();
    endtask

    // Holds res low for a few clks, checks the reset state, then releases res at a negedge.
    task automatic apply_reset();
        res     = 1'b0;
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {phi, cpu_res, mem_req, mem_we, op_fetch, mem_addr},
            {5'b0, 16'h0000});
        chk("reset_data", {mem_wdata, cpu_dbi}, 16'h0000);
        chk("reset_phi_count", phi_count, 32'd0);
        model_reset();
        res = 1'b1;
    endtask

    // Runs one full phi cycle, starting at a negedge that sees the first phi-low
    // clk. The ack is placed d clks after mem_req is first seen.
    task automatic run_cycle(input logic [15:0] ab, input logic rw, input logic [7:0] dbo,
                             input logic sync, input int d, input logic [7:0] rdata,
                             input int exp_hi, input logic exp_op);
        int          n_lo;
        int          n_hi;
        int          k;
        int          req_at;
        int          ack_at;
        int          n_op;
        logic        quiet_ok;
        logic        last_cres;
        logic        pre_res;
        logic [24:0] exp_t;
        cpu_ab   = ab;
        cpu_rw   = rw;
        cpu_dbo  = dbo;
        cpu_sync = sync;
        exp_q.push_back({~rw, ab, dbo});

        // PH1: cpu_dbi must hold, no request, and a spurious ack is ignored.
        n_lo     = 1;
        quiet_ok = (cpu_dbi === exp_dbi) && !mem_req && !op_fetch;
        @(negedge clk);
        mem_ack = 1'b0;
        while (!phi && n_lo < LIMIT) begin
            n_lo++;
            if (cpu_dbi !== exp_dbi || mem_req || op_fetch) quiet_ok = 1'b0;
            if (n_lo == 5) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'($urandom);
            end else begin
                mem_ack = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("ph1_len", n_lo, HALF);
        chk("ph1_quiet", quiet_ok, 1);

        // PH2: follow the transaction while phi is high.
        n_hi      = 0;
        req_at    = -1;
        ack_at    = -1;
        n_op      = 0;
        last_cres = cpu_res;
        while (phi && n_hi < LIMIT) begin
            k = n_hi;
            n_hi++;
            last_cres = cpu_res;
            if (op_fetch) n_op++;
            if (ack_at >= 0 && k == ack_at + 1) begin
                mem_ack = 1'b0;
                chk("req_drop", mem_req, 0);
            end
            if (req_at < 0 && mem_req) begin
                req_at = k;
                chk("req_latency", k, SETTLE + 1);
                exp_t = exp_q.pop_front();
                chk("mem_bus", {mem_we, mem_addr, mem_wdata}, exp_t);
            end
            if (req_at >= 0 && ack_at < 0 && k == req_at + d) begin
                chk("req_held", mem_req, 1);
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                ack_at    = k;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("req_seen", req_at >= 0, 1);
        if (req_at < 0 && exp_q.size() > 0) exp_t = exp_q.pop_front();

        // Model update for this bus cycle.
        pre_res = (exp_falls >= RPHI);
        if (rw) exp_dbi = rdata;
        exp_falls++;
        exp_pc = exp_pc + 32'd1;

        chk("phi_high_len", n_hi, exp_hi);
        chk("op_fetch", n_op, exp_op);
        chk("cpu_dbi", cpu_dbi, exp_dbi);
        chk("phi_count", phi_count, exp_pc);
        chk("cpu_res_before_fall", last_cres, pre_res);
        chk("cpu_res_after_fall", cpu_res, exp_falls >= RPHI);
    endtask

    function automatic int model_hi(input int d);
        int t;
        t = SETTLE + 1 + d + 2;
        return (t > HALF) ? t : HALF;
    endfunction

    initial begin
        int          n;
        int          d;
        logic        rw;
        logic        sync;
        logic [15:0] ab;
        logic [7:0]  dbo;
        logic [7:0]  rd;

        vecs[0] = '{16'h8000, 1'b1, 8'h00, 1'b1,  3, 8'hA9, 16, 1'b1};
        vecs[1] = '{16'h8001, 1'b1, 8'h00, 1'b0, 20, 8'h3C, 31, 1'b0};
        vecs[2] = '{16'h0200, 1'b0, 8'h5A, 1'b0,  0, 8'hFF, 16, 1'b0};
        vecs[3] = '{16'h0201, 1'b0, 8'hC3, 1'b1, 25, 8'h11, 36, 1'b1};
        vecs[4] = '{16'h1234, 1'b1, 8'h00, 1'b0,  5, 8'h77, 16, 1'b0};
        vecs[5] = '{16'h1235, 1'b1, 8'h00, 1'b0,  6, 8'h88, 17, 1'b0};
        vecs[6] = '{16'hFFFF, 1'b1, 8'h00, 1'b1,  1, 8'h00, 16, 1'b1};
        vecs[7] = '{16'h0000, 1'b0, 8'hFF, 1'b0,  6, 8'h12, 17, 1'b0};
        vecs[8] = '{16'hABCD, 1'b1, 8'h00, 1'b0,  7, 8'h5E, 18, 1'b0};

        // Reset and reset sequencing with zero-wait reads.
        apply_reset();
        for (int i = 0; i < RPHI + 1; i++) begin
            run_cycle(16'hFFFC + 16'(i), 1'b1, 8'h00, 1'b0, 0, 8'h10 + 8'(i), HALF, 1'b0);
        end

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_cycle(vecs[i].ab, vecs[i].rw, vecs[i].dbo, vecs[i].sync, vecs[i].d,
                      vecs[i].rdata, vecs[i].exp_hi, vecs[i].exp_op);
        end

        // Reset while waiting for a slow ack. The late ack must be ignored.
        cpu_ab   = 16'h4444;
        cpu_rw   = 1'b1;
        cpu_sync = 1'b0;
        n        = 0;
        while (!mem_req && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("abort_req_seen", mem_req, 1);
        res = 1'b0;
        @(negedge clk);
        chk("abort_state", {phi, mem_req, cpu_res, op_fetch}, 4'b0000);
        chk("abort_phi_count", phi_count, 32'd0);
        chk("abort_dbi", cpu_dbi, 8'h00);
        model_reset();
        res       = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 8'hEE;
        run_cycle(16'h0300, 1'b0, 8'h42, 1'b0, 2, 8'h99, HALF, 1'b0);

        // Randomized cycles.
        for (int i = 0; i < 30; i++) begin
            d    = $urandom_range(0, 25);
            rw   = 1'($urandom_range(0, 1));
            sync = 1'($urandom_range(0, 1));
            ab   = 16'($urandom);
            dbo  = 8'($urandom);
            rd   = 8'($urandom);
            run_cycle(ab, rw, dbo, sync, d, rd, model_hi(d), sync);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
